hash_result_scanner: RTL and testbench
======================================

// Module: hash_result_scanner
// PURPOSE
//  Read-side companion to the nonce-parallel SHA-256 miner: once the miner has written its NUM_NONCES
//  final hash words to the output region, this block reads them back over the same single-port memory bus.
//  Each word is compared against a 32-bit difficulty target. The block reports the first winning nonce,
//  the hit count and the minimum hash. Sits between the miner's output memory and the host/top-level control.
// PARAMETERS
//  NUM_NONCES   16   number of consecutive hash words scanned (one per nonce, word j <-> nonce j)
//  NONCE_W      4    $clog2(NUM_NONCES); width of nonce index outputs
// PORTS
//  clk             in   1        single clock for logic and memory
//  reset           in   1        asynchronous, active-high reset
//  start           in   1        begin scan; sampled only in IDLE or DONE
//  result_addr     in   16       base word address of hash region (as written by the miner)
//  target          in   32       difficulty target; latched on start accept
//  mem_clk         out  1        = clk
//  mem_we          out  1        always 0 (read-only master)
//  mem_addr        out  16       registered read address
//  mem_write_data  out  32       always 0
//  mem_read_data   in   32       read data from memory
//  done            out  1        results valid; level, held until next start accept or reset
//  found           out  1        at least one hash < target
//  first_nonce     out  NONCE_W  lowest j with hash[j] < target (0 if !found)
//  hit_count       out  NONCE_W+1 number of j with hash[j] < target
//  min_hash        out  32       minimum hash word over all j
//  min_nonce       out  NONCE_W  j of min_hash; ties -> lowest j
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, all outputs 0 (mem_we, mem_addr, done, found, first_nonce,
//    hit_count, min_hash, min_nonce); in-flight reads discarded.
//  - Memory timing: memory captures mem_addr at rising edge; data sampled by this block on the following
//    edge, so the word for an address registered at edge k is sampled at edge k+2. Reads are fully pipelined,
//    one address per cycle.
//  - FSM: IDLE -> FETCH -> DRAIN -> DONE -> (start) FETCH.
//    IDLE/DONE + start (edge 0): latch target/result_addr, mem_addr<=result_addr, clear done and
//      accumulators, enter FETCH.
//    FETCH: mem_addr increments each cycle through result_addr+NUM_NONCES-1, then DRAIN.
//    DRAIN: waits for the last 2 words in flight.
//    Word j compared at edge j+2; done rises at edge NUM_NONCES+2 (18 for default) with all results stable.
//  - start while in FETCH/DRAIN is ignored; no abort except reset.
//  - Compare: unsigned 32-bit, hit iff hash < target (strict). target=0 -> no hits.
//  - first_nonce is written only on the first hit; min tracking uses strict < so ties keep the lowest j.
//  - min_hash initialises from word 0 (not from 0xFFFFFFFF), so an all-0xFFFFFFFF region reports
//    min_nonce=0.
//  - Addresses are modulo 2^16: result_addr=0xFFF8 reads 0xFFF8..0xFFFF, 0x0000..0x0007.
//  - Outputs other than done/mem_* change only during a scan; they hold the last results in DONE.
// STRUCTURE
//  bitcoin_pkg: NUM_NONCES default, scan_state_t enum {IDLE,FETCH,DRAIN,DONE}, ADDR_W=16, WORD_W=32.
//  Sub-module result_tracker:
//    - inputs: valid, index, word, target, clear
//    - holds the found/first_nonce/hit_count/min_hash/min_nonce accumulators
//    - the top holds the FSM, address counter and a 2-deep valid/index shift register aligned to read latency.
// TESTING
//  1 word5=0x00001234, others 0xFFFFFFFF, target=0x00010000 -> found=1, first_nonce=5, hit_count=1,
//    min_hash=0x1234, min_nonce=5, done at edge 18.
//  2 all words 0x80000000, target=0x80000000 -> found=0, hit_count=0, first_nonce=0, min_hash=0x80000000,
//    min_nonce=0.
//  3 word j=0x20-j, target=0x18 -> found=1, first_nonce=9, hit_count=7, min_hash=0x11, min_nonce=15.
//  4 reset pulsed at edge 6 of a scan -> all outputs 0, IDLE. Restart at result_addr=0x0040 -> only
//    0x0040..0x004F read, correct results.
//  5 start held high through scan, then second scan with new target after done -> busy start ignored;
//    done low the edge after re-accept, second results correct.
//  6 result_addr=0xFFF8 -> addresses wrap to 0x0000..0x0007, each read exactly once, mem_we never 1.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// Shared constants and scan state encoding for the hash result scanner.
package bitcoin_pkg;

    localparam int unsigned NUM_NONCES = 16;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned WORD_W     = 32;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t IDLE  = 2'd0;
    localparam scan_state_t FETCH = 2'd1;
    localparam scan_state_t DRAIN = 2'd2;
    localparam scan_state_t DONE  = 2'd3;

endpackage

// File: rtl/hash_result_scanner_result_tracker.sv
// Accumulates hit/first-hit/minimum statistics over the hash words of one scan.
module result_tracker
    import bitcoin_pkg::*;
#(
    parameter int unsigned NONCE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                valid,
    input  logic [NONCE_W-1:0]  index,
    input  logic [WORD_W-1:0]   word,
    input  logic [WORD_W-1:0]   target,
    output logic                found,
    output logic [NONCE_W-1:0]  first_nonce,
    output logic [NONCE_W:0]    hit_count,
    output logic [WORD_W-1:0]   min_hash,
    output logic [NONCE_W-1:0]  min_nonce
);

    logic hit;

    assign hit = word < target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            found       <= 1'b0;
            first_nonce <= '0;
            hit_count   <= '0;
            min_hash    <= '0;
            min_nonce   <= '0;
        end else if (clear) begin
            found       <= 1'b0;
            first_nonce <= '0;
            hit_count   <= '0;
            min_hash    <= '0;
            min_nonce   <= '0;
        end else if (valid) begin
            if (hit) begin
                if (!found) begin
                    first_nonce <= index;
                end
                found     <= 1'b1;
                hit_count <= hit_count + (NONCE_W+1)'(1);
            end
            // Word 0 seeds the minimum; later words replace it only when strictly smaller.
            if (index == '0 || word < min_hash) begin
                min_hash  <= word;
                min_nonce <= index;
            end
        end
    end

endmodule

// File: rtl/hash_result_scanner.sv
// Reads back the miner's hash words, compares each to a target and reports the results.
module hash_result_scanner
    import bitcoin_pkg::*;
#(
    parameter int unsigned NUM_NONCES = bitcoin_pkg::NUM_NONCES,
    parameter int unsigned NONCE_W    = $clog2(NUM_NONCES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   result_addr,
    input  logic [WORD_W-1:0]   target,
    output logic                mem_clk,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_write_data,
    input  logic [WORD_W-1:0]   mem_read_data,
    output logic                done,
    output logic                found,
    output logic [NONCE_W-1:0]  first_nonce,
    output logic [NONCE_W:0]    hit_count,
    output logic [WORD_W-1:0]   min_hash,
    output logic [NONCE_W-1:0]  min_nonce
);

    localparam logic [NONCE_W-1:0] LAST_IDX = NONCE_W'(NUM_NONCES - 1);

    scan_state_t         state;
    logic [NONCE_W-1:0]  fetch_idx;
    logic [WORD_W-1:0]   target_q;
    logic                accept;
    // Two-stage valid/index pipe matching the address-to-data read latency.
    logic                v1, v2;
    logic [NONCE_W-1:0]  i1, i2;

    assign mem_clk        = clk;
    assign mem_we         = 1'b0;
    assign mem_write_data = '0;
    assign accept         = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            fetch_idx <= '0;
            target_q  <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            i1        <= '0;
            i2        <= '0;
            done      <= 1'b0;
        end else begin
            v1 <= 1'b0;
            v2 <= v1;
            i2 <= i1;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        target_q  <= target;
                        mem_addr  <= result_addr;
                        fetch_idx <= '0;
                        v1        <= 1'b1;
                        i1        <= '0;
                        done      <= 1'b0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (fetch_idx == LAST_IDX) begin
                        state <= DRAIN;
                    end else begin
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        fetch_idx <= fetch_idx + NONCE_W'(1);
                        v1        <= 1'b1;
                        i1        <= fetch_idx + NONCE_W'(1);
                    end
                end
                DRAIN: begin
                    if (!v1 && !v2) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    result_tracker #(
        .NONCE_W (NONCE_W)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .clear       (accept),
        .valid       (v2),
        .index       (i2),
        .word        (mem_read_data),
        .target      (target_q),
        .found       (found),
        .first_nonce (first_nonce),
        .hit_count   (hit_count),
        .min_hash    (min_hash),
        .min_nonce   (min_nonce)
    );

endmodule

// File: tb/tb_hash_result_scanner.sv
// Self-checking bench: behavioural memory plus reference model of scan results and timing.
module tb_hash_result_scanner;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        done;
    logic        found;
    logic [3:0]  first_nonce;
    logic [4:0]  hit_count;
    logic [31:0] min_hash;
    logic [3:0]  min_nonce;

    logic [31:0] mem [0:65535];

    int checks   = 0;
    int failures = 0;

    logic        exp_valid = 1'b0;
    logic        exp_found;
    logic [3:0]  exp_first;
    logic [4:0]  exp_hits;
    logic [31:0] exp_min;
    logic [3:0]  exp_min_nonce;

    hash_result_scanner #(
        .NUM_NONCES (16),
        .NONCE_W    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .result_addr    (result_addr),
        .target         (target),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .done           (done),
        .found          (found),
        .first_nonce    (first_nonce),
        .hit_count      (hit_count),
        .min_hash       (min_hash),
        .min_nonce      (min_nonce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous-read memory: address captured at an edge, data visible after it.
    always @(posedge clk) mem_read_data <= mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the rules: strict compare, first hit, count, lowest-index minimum.
    task automatic model(input logic [15:0] ra, input logic [31:0] tgt);
        logic [31:0] words [16];
        int          hits_q [$];
        logic [31:0] best;
        for (int j = 0; j < 16; j++) begin
            words[j] = mem[16'(ra + 16'(j))];
            if (words[j] < tgt) hits_q.push_back(j);
        end
        best = words[0];
        foreach (words[j]) if (words[j] < best) best = words[j];
        exp_found = (hits_q.size() != 0);
        exp_first = exp_found ? 4'(hits_q[0]) : 4'd0;
        exp_hits  = 5'(hits_q.size());
        exp_min   = best;
        exp_min_nonce = 4'd0;
        for (int j = 15; j >= 0; j--) if (words[j] == best) exp_min_nonce = 4'(j);
    endtask

    // Per-cycle comparison of outputs against the model whenever results are meaningful.
    always @(negedge clk) begin
        if (!reset) begin
            chk("mem_we", {31'd0, mem_we}, 32'd0);
            chk("mem_write_data", mem_write_data, 32'd0);
            if (done && exp_valid) begin
                chk("found", {31'd0, found}, {31'd0, exp_found});
                chk("first_nonce", {28'd0, first_nonce}, {28'd0, exp_first});
                chk("hit_count", {27'd0, hit_count}, {27'd0, exp_hits});
                chk("min_hash", min_hash, exp_min);
                chk("min_nonce", {28'd0, min_nonce}, {28'd0, exp_min_nonce});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_found"}, {31'd0, found}, 32'd0);
        chk({tag, "_first"}, {28'd0, first_nonce}, 32'd0);
        chk({tag, "_hits"}, {27'd0, hit_count}, 32'd0);
        chk({tag, "_min"}, min_hash, 32'd0);
        chk({tag, "_minn"}, {28'd0, min_nonce}, 32'd0);
        chk({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    endtask

    // Accepts a scan at edge 0, checks the address sequence and that done rises exactly at edge 18.
    task automatic run_scan(input logic [15:0] ra, input logic [31:0] tgt, input bit hold);
        @(negedge clk);
        start = 1'b1;
        result_addr = ra;
        target = tgt;
        @(posedge clk);
        #1;
        model(ra, tgt);
        exp_valid = 1'b1;
        if (!hold) start = 1'b0;
        // New random inputs on busy cycles must not disturb the scan.
        result_addr = 16'($urandom);
        target = $urandom;
        chk("addr_e0", {16'd0, mem_addr}, {16'd0, ra});
        chk("done_low_after_accept", {31'd0, done}, 32'd0);
        for (int e = 1; e <= 18; e++) begin
            @(posedge clk);
            #1;
            if (e <= 15) chk("addr_seq", {16'd0, mem_addr}, {16'd0, 16'(ra + 16'(e))});
            if (e <= 17) chk("done_early", {31'd0, done}, 32'd0);
            else chk("done_at_18", {31'd0, done}, 32'd1);
            if (hold && e == 17) start = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic fill_random(input logic [15:0] ra);
        for (int j = 0; j < 16; j++) begin
            case ($urandom_range(0, 3))
                0: mem[16'(ra + 16'(j))] = $urandom_range(0, 3);
                1: mem[16'(ra + 16'(j))] = 32'h0000_1000 + $urandom_range(0, 2);
                default: mem[16'(ra + 16'(j))] = $urandom;
            endcase
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [31:0] tgt;
        reset = 1'b1;
        start = 1'b0;
        result_addr = '0;
        target = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 32'hFFFF_FFFF;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: single small word at index 5
        for (int j = 0; j < 16; j++) mem[16'h0100 + j] = 32'hFFFF_FFFF;
        mem[16'h0105] = 32'h0000_1234;
        run_scan(16'h0100, 32'h0001_0000, 1'b0);
        chk("t1_found", {31'd0, found}, 32'd1);
        chk("t1_first", {28'd0, first_nonce}, 32'd5);
        chk("t1_hits", {27'd0, hit_count}, 32'd1);
        chk("t1_min", min_hash, 32'h0000_1234);
        chk("t1_minn", {28'd0, min_nonce}, 32'd5);

        // 2: all equal to target, strict compare means no hits
        for (int j = 0; j < 16; j++) mem[16'h0200 + j] = 32'h8000_0000;
        run_scan(16'h0200, 32'h8000_0000, 1'b0);
        chk("t2_found", {31'd0, found}, 32'd0);
        chk("t2_hits", {27'd0, hit_count}, 32'd0);
        chk("t2_first", {28'd0, first_nonce}, 32'd0);
        chk("t2_min", min_hash, 32'h8000_0000);
        chk("t2_minn", {28'd0, min_nonce}, 32'd0);

        // 3: descending words
        for (int j = 0; j < 16; j++) mem[16'h0300 + j] = 32'h20 - 32'(j);
        run_scan(16'h0300, 32'h18, 1'b0);
        chk("t3_found", {31'd0, found}, 32'd1);
        chk("t3_first", {28'd0, first_nonce}, 32'd9);
        chk("t3_hits", {27'd0, hit_count}, 32'd7);
        chk("t3_min", min_hash, 32'h11);
        chk("t3_minn", {28'd0, min_nonce}, 32'd15);

        // all 0xFFFFFFFF region: min from word 0
        run_scan(16'h0500, 32'hFFFF_FFFF, 1'b0);
        chk("ff_minn", {28'd0, min_nonce}, 32'd0);
        chk("ff_min", min_hash, 32'hFFFF_FFFF);

        // 4: reset mid-scan, then restart at 0x0040
        fill_random(16'h0600);
        @(negedge clk);
        start = 1'b1;
        result_addr = 16'h0600;
        target = 32'h8000_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        fill_random(16'h0040);
        run_scan(16'h0040, 32'h0000_1001, 1'b0);

        // 5: start held through a scan, then re-accept with a new target
        fill_random(16'h0700);
        run_scan(16'h0700, 32'h0000_1002, 1'b1);
        run_scan(16'h0700, 32'h0000_0002, 1'b0);

        // 6: address wrap
        fill_random(16'hFFF8);
        run_scan(16'hFFF8, 32'h0000_1001, 1'b0);

        // Target 0 never hits
        run_scan(16'hFFF8, 32'h0, 1'b0);
        chk("t0_found", {31'd0, found}, 32'd0);
        chk("t0_hits", {27'd0, hit_count}, 32'd0);

        // Random scans
        for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom);
            fill_random(ra);
            case ($urandom_range(0, 2))
                0: tgt = $urandom;
                1: tgt = $urandom_range(0, 4);
                default: tgt = 32'h0000_1000 + $urandom_range(0, 3);
            endcase
            run_scan(ra, tgt, n[0]);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
